// File: rtl/operand_stage_pkg.sv
// Shared operand-source encodings and skid-buffer occupancy states.
// Imported by the operand stage and by the control decoder that drives a_sel/b_sel.
package operand_stage_pkg;

  typedef enum logic {
    A_SRC_REG = 1'b0,
    A_SRC_PC  = 1'b1
  } a_src_e;

  typedef enum logic [1:0] {
    B_SRC_REG   = 2'b00,
    B_SRC_EXT   = 2'b01,
    B_SRC_CONST = 2'b10,
    B_SRC_RSVD  = 2'b11
  } b_src_e;

  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_ONE   = 2'b01,
    SB_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/operand_stage_if.sv
// Decode-side and execute-side signals of the operand stage.
// The slave modport is the stage itself; the master modport is its surroundings.
interface operand_stage_if #(
  parameter int DATA_W = 32
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] ext_in;
  logic [DATA_W-1:0] pc_in;
  logic              a_sel;
  logic [1:0]        b_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] a_out;
  logic [DATA_W-1:0] b_out;
  logic [DATA_W-1:0] store_out;

  modport master (
    output flush, in_valid, a_in, b_in, ext_in, pc_in, a_sel, b_sel, out_ready,
    input  in_ready, out_valid, a_out, b_out, store_out
  );

  modport slave (
    input  flush, in_valid, a_in, b_in, ext_in, pc_in, a_sel, b_sel, out_ready,
    output in_ready, out_valid, a_out, b_out, store_out
  );

endinterface

// File: rtl/operand_stage_skid_buffer.sv
// Generic two-entry valid/ready register: a main entry drives the outputs, a skid entry
// absorbs the one extra beat that arrives while in_ready is still high from the previous cycle.
module operand_stage_skid_buffer
  import operand_stage_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] mainData_q, skidData_q;
  logic              acc, pop;
  logic              loadMain, mainFromSkid, loadSkid;

  // in_ready depends only on the state register, so it never combinationally follows out_ready.
  assign in_ready_o  = (state_q != SB_FULL);
  assign out_valid_o = (state_q != SB_EMPTY);
  assign out_data_o  = mainData_q;
  assign acc         = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SB_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    loadMain     = 1'b0;
    mainFromSkid = 1'b0;
    loadSkid     = 1'b0;
    if (flush_i) begin
      state_d = SB_EMPTY;
    end else begin
      case (state_q)
        SB_EMPTY: begin
          if (acc) begin
            state_d  = SB_ONE;
            loadMain = 1'b1;
          end
        end
        SB_ONE: begin
          if (pop && acc) begin
            loadMain = 1'b1;
          end else if (pop) begin
            state_d = SB_EMPTY;
          end else if (acc) begin
            state_d  = SB_FULL;
            loadSkid = 1'b1;
          end
        end
        SB_FULL: begin
          if (pop) begin
            state_d      = SB_ONE;
            loadMain     = 1'b1;
            mainFromSkid = 1'b1;
          end
        end
        default: state_d = SB_EMPTY;
      endcase
    end
  end

  // Data registers carry no valid bit of their own, so a flush may leave stale contents here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainData_q <= '0;
      skidData_q <= '0;
    end else begin
      if (loadMain) begin
        mainData_q <= mainFromSkid ? skidData_q : in_data_i;
      end
      if (loadSkid) begin
        skidData_q <= in_data_i;
      end
    end
  end

endmodule

// File: rtl/operand_stage.sv
// Operand register between register-read and execute: selects ALU operands A/B, carries raw
// store data alongside, and decouples the two stages through a two-entry skid buffer.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter     CONST_B = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  operand_stage_if.slave  bus
);

  localparam logic [DATA_W-1:0] CONST_B_TRUNC = DATA_W'(CONST_B);

  logic [DATA_W-1:0]   aMux, bMux;
  logic [3*DATA_W-1:0] outData;

  always_comb begin
    aMux = (bus.a_sel == A_SRC_PC) ? bus.pc_in : bus.a_in;
    case (bus.b_sel)
      B_SRC_EXT:   bMux = bus.ext_in;
      B_SRC_CONST: bMux = CONST_B_TRUNC;
      default:     bMux = bus.b_in;
    endcase
  end

  operand_stage_skid_buffer #(
    .DATA_W(3 * DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (bus.flush),
    .in_valid_i (bus.in_valid),
    .in_ready_o (bus.in_ready),
    .in_data_i  ({aMux, bMux, bus.b_in}),
    .out_valid_o(bus.out_valid),
    .out_ready_i(bus.out_ready),
    .out_data_o (outData)
  );

  assign {bus.a_out, bus.b_out, bus.store_out} = outData;

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed scenarios followed by random traffic,
// all compared against a FIFO-of-two reference model of the stage.
module tb_operand_stage;
  import operand_stage_pkg::*;

  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  operand_stage_if #(.DATA_W(DATA_W)) bus ();

  operand_stage #(
    .DATA_W (DATA_W),
    .CONST_B(32'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount = 0;
  logic [3*DATA_W-1:0] modelQ[$];

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] expectB(input logic [1:0] bSel,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] ext);
    if (bSel == 2'b01) return ext;
    if (bSel == 2'b10) return 32'd4;
    return b;
  endfunction

  task automatic compareModel(input string tag);
    logic [3*DATA_W-1:0] head;
    checkOutput({tag, ".out_valid"}, DATA_W'(bus.out_valid), DATA_W'(modelQ.size() > 0));
    checkOutput({tag, ".in_ready"}, DATA_W'(bus.in_ready), DATA_W'(modelQ.size() < 2));
    if (modelQ.size() > 0) begin
      head = modelQ[0];
      checkOutput({tag, ".a_out"}, bus.a_out, head[3*DATA_W-1:2*DATA_W]);
      checkOutput({tag, ".b_out"}, bus.b_out, head[2*DATA_W-1:DATA_W]);
      checkOutput({tag, ".store_out"}, bus.store_out, head[DATA_W-1:0]);
    end
  endtask

  // Drives one cycle of inputs, advances the model across the edge, and returns at the next negedge.
  task automatic applyStimulus(input logic inValid, input logic [DATA_W-1:0] a,
                               input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] ext,
                               input logic [DATA_W-1:0] pc, input logic aSel,
                               input logic [1:0] bSel, input logic outReady,
                               input logic fl, output logic accepted);
    logic [DATA_W-1:0] expA;
    logic pop;
    bus.in_valid  = inValid;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.ext_in    = ext;
    bus.pc_in     = pc;
    bus.a_sel     = aSel;
    bus.b_sel     = bSel;
    bus.out_ready = outReady;
    bus.flush     = fl;
    accepted = inValid && (modelQ.size() < 2) && !fl;
    pop = (modelQ.size() > 0) && outReady;
    expA = aSel ? pc : a;
    if (fl) begin
      modelQ.delete();
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (accepted) modelQ.push_back({expA, expectB(bSel, b, ext), b});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic outReady);
    logic acc;
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 2'b00, outReady, 1'b0, acc);
  endtask

  initial begin
    logic acc;
    logic [DATA_W-1:0] r0, r1, r2, r3;

    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0;
    bus.ext_in = '0; bus.pc_in = '0; bus.a_sel = 1'b0; bus.b_sel = 2'b00;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset.out_valid", DATA_W'(bus.out_valid), 0);
    checkOutput("reset.in_ready", DATA_W'(bus.in_ready), 1);
    checkOutput("reset.a_out", bus.a_out, 0);
    checkOutput("reset.b_out", bus.b_out, 0);
    checkOutput("reset.store_out", bus.store_out, 0);
    rst_n = 1'b1;

    applyStimulus(1'b1, 32'h11, 32'h22, 32'hFFFF_FFF0, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, acc);
    checkOutput("single.out_valid", DATA_W'(bus.out_valid), 1);
    checkOutput("single.a_out", bus.a_out, 32'h11);
    checkOutput("single.b_out", bus.b_out, 32'hFFFF_FFF0);
    checkOutput("single.store_out", bus.store_out, 32'h22);
    idle(1'b1);
    compareModel("single.drain");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'h100 + i, 32'h200 + i, 32'h300 + i, 32'h0, 1'b0, 2'(i % 3),
                    1'b1, 1'b0, acc);
      checkOutput("stream.accepted", DATA_W'(acc), 1);
      compareModel("stream");
    end
    idle(1'b1);
    compareModel("stream.drain");

    applyStimulus(1'b1, 32'hA1, 32'hB1, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc);
    compareModel("bp.set1");
    applyStimulus(1'b1, 32'hA2, 32'hB2, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc);
    compareModel("bp.set2");
    checkOutput("bp.in_ready_low", DATA_W'(bus.in_ready), 0);
    checkOutput("bp.hold_set1", bus.a_out, 32'hA1);
    applyStimulus(1'b1, 32'hA3, 32'hB3, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc);
    compareModel("bp.stall");
    checkOutput("bp.hold_set1_again", bus.a_out, 32'hA1);
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      applyStimulus(1'b1, 32'hA3, 32'hB3, 32'h0, 32'h0, 1'b0, 2'b00, 1'b1, 1'b0, acc);
      compareModel("bp.release");
    end
    checkOutput("bp.set3_accepted", DATA_W'(acc), 1);
    repeat (3) begin
      idle(1'b1);
      compareModel("bp.drain");
    end

    applyStimulus(1'b1, 32'h7, 32'h9, 32'h0, 32'h400, 1'b1, 2'b10, 1'b1, 1'b0, acc);
    checkOutput("sel.a_pc", bus.a_out, 32'h400);
    checkOutput("sel.b_const", bus.b_out, 32'd4);
    applyStimulus(1'b1, 32'h7, 32'h5A, 32'h33, 32'h400, 1'b0, 2'b11, 1'b1, 1'b0, acc);
    checkOutput("sel.a_reg", bus.a_out, 32'h7);
    checkOutput("sel.b_rsvd", bus.b_out, 32'h5A);
    idle(1'b1);

    applyStimulus(1'b1, 32'hC1, 32'hD1, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hC2, 32'hD2, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc);
    compareModel("flush.full");
    applyStimulus(1'b1, 32'hC3, 32'hD3, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, acc);
    checkOutput("flush.out_valid", DATA_W'(bus.out_valid), 0);
    checkOutput("flush.in_ready", DATA_W'(bus.in_ready), 1);
    repeat (3) begin
      idle(1'b1);
      compareModel("flush.after");
    end

    applyStimulus(1'b1, 32'hE1, 32'hF1, 32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, acc);
    compareModel("arst.loaded");
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkOutput("arst.out_valid_drop", DATA_W'(bus.out_valid), 0);
    modelQ.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("arst.in_ready", DATA_W'(bus.in_ready), 1);
    checkOutput("arst.a_out", bus.a_out, 0);
    checkOutput("arst.b_out", bus.b_out, 0);
    checkOutput("arst.store_out", bus.store_out, 0);
    @(negedge clk);
    applyStimulus(1'b1, 32'h51, 32'h52, 32'h53, 32'h54, 1'b0, 2'b00, 1'b0, 1'b0, acc);
    compareModel("arst.first_edge");

    for (int i = 0; i < 400; i++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      applyStimulus(($urandom_range(3) != 0), r0, r1, r2, r3, 1'($urandom_range(1)),
                    2'($urandom_range(3)), ($urandom_range(3) != 0),
                    ($urandom_range(15) == 0), acc);
      compareModel("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
